cacheline_adapter: RTL and testbench

Memory-side responder for the cache's physical-memory port. It accepts one 256-bit line read or write from a cache (`pmem_read`/`pmem_write`, `pmem_address`, `pmem_wdata`/`pmem_rdata`, `mem_resp`). It converts that request into a 4-beat, 64-bit burst on the main-memory interface. It sits between the icache/dcache datapaths (or their arbiter) and main memory, and returns the assembled line with a single-cycle response pulse.

---
 rtl/cacheline_adapter.sv | 91 +++++++++
 tb/tb_cacheline_adapter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: turns one cache line read/write into a burst of s_line/s_beat memory beats
module cacheline_adapter #(
    parameter int s_line = 256,
    parameter int s_beat = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [s_line-1:0] pmem_wdata,
    output logic [s_line-1:0] pmem_rdata,
    output logic              mem_resp,
    output logic              burst_read,
    output logic              burst_write,
    output logic [31:0]       burst_address,
    output logic [s_beat-1:0] burst_wdata,
    input  logic [s_beat-1:0] burst_rdata,
    input  logic              burst_resp
);
    localparam int beats = s_line / s_beat;
    localparam int cw = beats > 1 ? $clog2(beats) : 1;
    localparam int lsb = $clog2(s_line / 8);
    localparam logic [cw-1:0] last = cw'(beats - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t state;
    logic [cw-1:0] cnt;
    logic [cw-1:0] nxt;
    logic [s_line-1:0] line;
    logic [31:0] aligned;

    assign nxt = cnt + 1'b1;
    assign aligned = {pmem_address[31:lsb], lsb'(0)};

    // the last beat of either burst clears the burst outputs so DONE presents them as 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            line <= '0;
            pmem_rdata <= '0;
            mem_resp <= 1'b0;
            burst_read <= 1'b0;
            burst_write <= 1'b0;
            burst_address <= '0;
            burst_wdata <= '0;
        end else begin
            mem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pmem_write) begin
                        state <= WRITE;
                        line <= pmem_wdata;
                        burst_address <= aligned;
                        burst_write <= 1'b1;
                        burst_wdata <= pmem_wdata[s_beat-1:0];
                    end else if (pmem_read) begin
                        state <= READ;
                        burst_address <= aligned;
                        burst_read <= 1'b1;
                    end
                end
                READ: if (burst_resp) begin
                    pmem_rdata[int'(cnt)*s_beat +: s_beat] <= burst_rdata;
                    cnt <= nxt;
                    if (cnt == last) begin
                        state <= DONE;
                        mem_resp <= 1'b1;
                        burst_read <= 1'b0;
                        burst_address <= '0;
                    end
                end
                WRITE: if (burst_resp) begin
                    cnt <= nxt;
                    burst_wdata <= line[int'(nxt)*s_beat +: s_beat];
                    if (cnt == last) begin
                        state <= DONE;
                        mem_resp <= 1'b1;
                        burst_write <= 1'b0;
                        burst_address <= '0;
                        burst_wdata <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: directed scenarios for the line-to-burst adapter
module tb_cacheline_adapter;
    logic clk = 1'b0;
    logic rst;
    logic pmem_read, pmem_write;
    logic [31:0] pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic mem_resp, burst_read, burst_write, burst_resp;
    logic [31:0] burst_address;
    logic [63:0] burst_wdata, burst_rdata;
    int checks = 0;
    int errors = 0;
    logic [255:0] last_line;

    cacheline_adapter dut (
        .clk(clk), .rst(rst),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .mem_resp(mem_resp),
        .burst_read(burst_read), .burst_write(burst_write),
        .burst_address(burst_address), .burst_wdata(burst_wdata),
        .burst_rdata(burst_rdata), .burst_resp(burst_resp)
    );

    always #5 clk = ~clk;

    task test_reset;
        rst = 1'b1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        pmem_address = '0;
        pmem_wdata = '0;
        burst_rdata = '0;
        burst_resp = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_resp, burst_read, burst_write} !== 3'b000 || burst_address !== 0 || burst_wdata !== 0 || pmem_rdata !== 0) begin
            errors++;
            $display("FAIL reset_values resp=%b rd=%b wr=%b addr=%h wdata=%h rdata_nonzero=%b expected all 0",
                     mem_resp, burst_read, burst_write, burst_address, burst_wdata, |pmem_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (burst_read !== 1'b0 || burst_write !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset rd=%b wr=%b expected 0 0", burst_read, burst_write);
        end
    endtask

    task test_read_nowait;
        logic [255:0] exp;
        pmem_read = 1'b1;
        pmem_address = 32'h0000_1234;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (burst_read !== 1'b1 || burst_write !== 1'b0 || burst_address !== 32'h0000_1220 || mem_resp !== 1'b0) begin
                errors++;
                $display("FAIL read_nowait_beat%0d rd=%b wr=%b addr=%h resp=%b expected 1 0 00001220 0",
                         k, burst_read, burst_write, burst_address, mem_resp);
            end
            burst_resp = 1'b1;
            burst_rdata = 64'h1111_1111_1111_1111 * 64'(k + 1);
            exp[k*64 +: 64] = burst_rdata;
            @(negedge clk);
        end
        burst_resp = 1'b0;
        checks++;
        if (mem_resp !== 1'b1 || burst_read !== 1'b0 || burst_address !== 0 || pmem_rdata !== exp) begin
            errors++;
            $display("FAIL read_nowait_done resp=%b rd=%b addr=%h rdata=%h expected 1 0 0 %h",
                     mem_resp, burst_read, burst_address, pmem_rdata, exp);
        end
        pmem_read = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0 || pmem_rdata !== exp) begin
            errors++;
            $display("FAIL read_nowait_pulse resp=%b rdata=%h expected 0 %h", mem_resp, pmem_rdata, exp);
        end
    endtask

    task test_read_waits;
        int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
        logic [255:0] exp;
        int k;
        k = 0;
        pmem_read = 1'b1;
        pmem_address = 32'h0000_ABCD;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (burst_read !== 1'b1 || burst_address !== 32'h0000_ABC0 || mem_resp !== 1'b0) begin
                errors++;
                $display("FAIL read_waits_cycle%0d rd=%b addr=%h resp=%b expected 1 0000abc0 0",
                         i, burst_read, burst_address, mem_resp);
            end
            if (i == 0) pmem_address = 32'hFFFF_FFFF;
            burst_resp = pat[i][0];
            burst_rdata = pat[i] == 1 ? {32'hCAFE_0000 + 32'(k), 32'h0000_BEEF + 32'(k)} : 64'hDEAD_DEAD_DEAD_DEAD;
            if (pat[i] == 1) begin
                exp[k*64 +: 64] = burst_rdata;
                k++;
            end
            @(negedge clk);
        end
        burst_resp = 1'b0;
        checks++;
        if (mem_resp !== 1'b1 || burst_read !== 1'b0 || pmem_rdata !== exp) begin
            errors++;
            $display("FAIL read_waits_done resp=%b rd=%b rdata=%h expected 1 0 %h", mem_resp, burst_read, pmem_rdata, exp);
        end
        pmem_read = 1'b0;
        last_line = exp;
        @(negedge clk);
    endtask

    task test_write;
        int pat[6] = '{1, 0, 1, 1, 0, 1};
        int k;
        k = 0;
        pmem_write = 1'b1;
        pmem_address = 32'h8000_0040;
        pmem_wdata = {64'd3, 64'd2, 64'd1, 64'd0};
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (burst_write !== 1'b1 || burst_read !== 1'b0 || burst_wdata !== 64'(k) || burst_address !== 32'h8000_0040 || mem_resp !== 1'b0) begin
                errors++;
                $display("FAIL write_cycle%0d wr=%b rd=%b wdata=%h addr=%h resp=%b expected 1 0 %h 80000040 0",
                         i, burst_write, burst_read, burst_wdata, burst_address, mem_resp, 64'(k));
            end
            if (i == 0) begin
                pmem_wdata = {4{64'hBAD0_BAD0_BAD0_BAD0}};
                pmem_address = 32'h1234_5678;
            end
            burst_resp = pat[i][0];
            burst_rdata = 64'h5555_5555_5555_5555;
            k += pat[i];
            @(negedge clk);
        end
        burst_resp = 1'b0;
        checks++;
        if (mem_resp !== 1'b1 || burst_write !== 1'b0 || burst_wdata !== 0 || pmem_rdata !== last_line) begin
            errors++;
            $display("FAIL write_done resp=%b wr=%b wdata=%h rdata=%h expected 1 0 0 %h",
                     mem_resp, burst_write, burst_wdata, pmem_rdata, last_line);
        end
        pmem_write = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0 || burst_write !== 1'b0) begin
            errors++;
            $display("FAIL write_pulse resp=%b wr=%b expected 0 0", mem_resp, burst_write);
        end
    endtask

    task test_both;
        logic [255:0] exp;
        pmem_read = 1'b1;
        pmem_write = 1'b1;
        pmem_address = 32'h0000_0100;
        pmem_wdata = {64'hD, 64'hC, 64'hB, 64'hA};
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (burst_write !== 1'b1 || burst_read !== 1'b0 || burst_wdata !== 64'(10 + k)) begin
                errors++;
                $display("FAIL both_write_beat%0d wr=%b rd=%b wdata=%h expected 1 0 %h",
                         k, burst_write, burst_read, burst_wdata, 64'(10 + k));
            end
            burst_resp = 1'b1;
            @(negedge clk);
        end
        burst_resp = 1'b0;
        checks++;
        if (mem_resp !== 1'b1 || burst_write !== 1'b0 || burst_read !== 1'b0) begin
            errors++;
            $display("FAIL both_write_done resp=%b wr=%b rd=%b expected 1 0 0", mem_resp, burst_write, burst_read);
        end
        pmem_write = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0 || burst_write !== 1'b0 || burst_read !== 1'b0) begin
            errors++;
            $display("FAIL both_idle resp=%b wr=%b rd=%b expected 0 0 0", mem_resp, burst_write, burst_read);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (burst_read !== 1'b1 || burst_write !== 1'b0 || burst_address !== 32'h0000_0100) begin
                errors++;
                $display("FAIL both_read_beat%0d rd=%b wr=%b addr=%h expected 1 0 00000100",
                         k, burst_read, burst_write, burst_address);
            end
            burst_resp = 1'b1;
            burst_rdata = 64'h0F0F_0000_0000_0000 + 64'(k);
            exp[k*64 +: 64] = burst_rdata;
            @(negedge clk);
        end
        burst_resp = 1'b0;
        checks++;
        if (mem_resp !== 1'b1 || pmem_rdata !== exp) begin
            errors++;
            $display("FAIL both_read_done resp=%b rdata=%h expected 1 %h", mem_resp, pmem_rdata, exp);
        end
        pmem_read = 1'b0;
        @(negedge clk);
    endtask

    task test_reset_mid;
        logic [255:0] exp;
        pmem_read = 1'b1;
        pmem_address = 32'h0000_2000;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            burst_resp = 1'b1;
            burst_rdata = 64'h7777_7777_7777_7777;
            @(negedge clk);
        end
        burst_resp = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({mem_resp, burst_read, burst_write} !== 3'b000 || burst_address !== 0 || burst_wdata !== 0 || pmem_rdata !== 0) begin
            errors++;
            $display("FAIL async_reset resp=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h expected all 0",
                     mem_resp, burst_read, burst_write, burst_address, burst_wdata, pmem_rdata);
        end
        @(negedge clk);
        checks++;
        if (mem_resp !== 1'b0 || burst_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold resp=%b rd=%b expected 0 0", mem_resp, burst_read);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (burst_read !== 1'b1 || burst_address !== 32'h0000_2000 || mem_resp !== 1'b0) begin
                errors++;
                $display("FAIL restart_beat%0d rd=%b addr=%h resp=%b expected 1 00002000 0",
                         k, burst_read, burst_address, mem_resp);
            end
            burst_resp = 1'b1;
            burst_rdata = 64'h9000_0000_0000_0000 + 64'(k);
            exp[k*64 +: 64] = burst_rdata;
            @(negedge clk);
        end
        burst_resp = 1'b0;
        checks++;
        if (mem_resp !== 1'b1 || pmem_rdata !== exp) begin
            errors++;
            $display("FAIL restart_done resp=%b rdata=%h expected 1 %h", mem_resp, pmem_rdata, exp);
        end
        pmem_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_read_nowait;
        test_read_waits;
        test_write;
        test_both;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
